// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the pulse-width meter.
package pulse_meter_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  typedef struct packed {
    logic                 level;
    logic                 sat;
    logic [CNT_W_DEF-1:0] cnt;
  } entry_t;

endpackage

// File: rtl/pulse_meter_fifo.sv
// Generic registered FIFO; head is read combinationally from storage.
module pulse_meter_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign head  = mem_q[rd_q];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push) wr_d = wr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/pulse_meter.sv
// Measures high-pulse widths of a filtered level and queues them for readout.
// Define PULSE_METER_LOW_EN to also measure and report the low gaps between pulses.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] meas_data,
  output logic             meas_level,
  output logic             meas_sat,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             ovf,
  input  logic             clr_ovf
);

  typedef struct packed {
    logic             level;
    logic             sat;
    logic [CNT_W-1:0] cnt;
  } meas_entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             sig_dly_q;
  logic             ovf_q, ovf_d;
  logic             rise, fall;
  logic             push, pop, full, empty;
  meas_entry_t      push_entry, head;

  assign rise = sig_in & ~sig_dly_q;
  assign fall = ~sig_in & sig_dly_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    push       = 1'b0;
    push_entry = '{level: 1'b1, sat: sat_q, cnt: cnt_q};
    case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = CNT_W'(1);
          sat_d   = 1'b0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          push  = 1'b1;
          sat_d = 1'b0;
`ifdef PULSE_METER_LOW_EN
          // The sample that saw the fall is the first low cycle of the gap.
          cnt_d   = CNT_W'(1);
          state_d = LOW;
`else
          cnt_d   = '0;
          state_d = IDLE;
`endif
        end else if (sig_in) begin
          cnt_d = sat_inc(cnt_q);
          if (&cnt_q) sat_d = 1'b1;
        end
      end
`ifdef PULSE_METER_LOW_EN
      LOW: begin
        if (rise) begin
          push             = 1'b1;
          push_entry.level = 1'b0;
          cnt_d            = CNT_W'(1);
          sat_d            = 1'b0;
          state_d          = HIGH;
        end else if (!sig_in) begin
          cnt_d = sat_inc(cnt_q);
          if (&cnt_q) sat_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign pop = meas_ready & ~empty;

  // A drop on the same edge as a clear leaves the flag set.
  always_comb begin
    ovf_d = clr_ovf ? 1'b0 : ovf_q;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      sig_dly_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      sig_dly_q <= sig_in;
      ovf_q     <= ovf_d;
    end
  end

  pulse_meter_fifo #(
    .W     ($bits(meas_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Storage is not reset, so the outputs read as zero whenever nothing is queued.
  assign meas_valid = ~empty;
  assign meas_data  = empty ? '0 : head.cnt;
  assign meas_sat   = ~empty & head.sat;
  assign meas_level = ~empty & head.level;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: a default-width instance and a 4-bit-counter instance.
module tb_pulse_meter;

  logic        clock = 1'b0;
  logic        reset;
  logic        sig_in;
  logic        meas_ready;
  logic        clr_ovf;

  logic [15:0] a_data;
  logic        a_level, a_sat, a_valid, a_ovf;
  logic [3:0]  b_data;
  logic        b_level, b_sat, b_valid, b_ovf;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clock = ~clock;

  pulse_meter dut (
    .clock      (clock),
    .reset      (reset),
    .sig_in     (sig_in),
    .meas_data  (a_data),
    .meas_level (a_level),
    .meas_sat   (a_sat),
    .meas_valid (a_valid),
    .meas_ready (meas_ready),
    .ovf        (a_ovf),
    .clr_ovf    (clr_ovf)
  );

  pulse_meter #(.CNT_W(4), .FIFO_DEPTH(4)) dut4 (
    .clock      (clock),
    .reset      (reset),
    .sig_in     (sig_in),
    .meas_data  (b_data),
    .meas_level (b_level),
    .meas_sat   (b_sat),
    .meas_valid (b_valid),
    .meas_ready (meas_ready),
    .ovf        (b_ovf),
    .clr_ovf    (clr_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // High for n sampled edges, then one low sample (the push edge).
  task automatic pulse(input int n);
    sig_in = 1'b1;
    repeat (n) @(negedge clock);
    sig_in = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_head(input string tag, input int data, input logic level);
    check({tag, "_valid"}, a_valid, 1'b1);
    check({tag, "_data"},  a_data,  data);
    check({tag, "_level"}, a_level, level);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    sig_in     = 1'b0;
    meas_ready = 1'b0;
    clr_ovf    = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_valid", a_valid, 1'b0);
    check("rst_ovf",   a_ovf,   1'b0);
    check("rst_data",  a_data,  16'd0);
    check("rst_level", a_level, 1'b0);
    check("rst_sat",   a_sat,   1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("idle_valid", a_valid, 1'b0);
      check("idle_ovf",   a_ovf,   1'b0);
    end

`ifndef PULSE_METER_LOW_EN
    // Single 5-cycle pulse, consumer ready.
    meas_ready = 1'b1;
    sig_in = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("during_pulse_valid", a_valid, 1'b0);
    end
    sig_in = 1'b0;
    @(negedge clock);
    check_head("p5", 5, 1'b1);
    check("p5_sat", a_sat, 1'b0);
    @(negedge clock);
    check("p5_popped", a_valid, 1'b0);

    // 20-cycle pulse: saturates the 4-bit instance only.
    pulse(20);
    check("p20_data", a_data, 16'd20);
    check("p20_sat",  a_sat,  1'b0);
    check("sat_valid", b_valid, 1'b1);
    check("sat_data",  b_data,  4'd15);
    check("sat_sat",   b_sat,   1'b1);
    check("sat_level", b_level, 1'b1);
    @(negedge clock);
    check("sat_popped", b_valid, 1'b0);

    // Five 3-cycle pulses into a depth-4 FIFO with no consumer.
    meas_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(3);
    check("fill4_ovf",  a_ovf,   1'b0);
    check_head("fill4", 3, 1'b1);
    pulse(3);
    check("drop_ovf", a_ovf, 1'b1);
    clr_ovf = 1'b1;
    @(negedge clock);
    clr_ovf = 1'b0;
    check("clr_ovf", a_ovf, 1'b0);
    // Clear and drop on the same edge: the drop wins.
    sig_in = 1'b1;
    repeat (3) @(negedge clock);
    sig_in  = 1'b0;
    clr_ovf = 1'b1;
    @(negedge clock);
    clr_ovf = 1'b0;
    check("clr_vs_drop_ovf", a_ovf, 1'b1);
    clr_ovf = 1'b1;
    @(negedge clock);
    clr_ovf = 1'b0;
    check("clr2_ovf", a_ovf, 1'b0);
    meas_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head("drain3", 3, 1'b1);
      @(negedge clock);
    end
    check("drain3_empty", a_valid, 1'b0);
    meas_ready = 1'b0;

    // Full FIFO: pop and push on the same edge.
    for (int w = 2; w <= 5; w++) pulse(w);
    check_head("full_head", 2, 1'b1);
    sig_in = 1'b1;
    repeat (6) @(negedge clock);
    sig_in     = 1'b0;
    meas_ready = 1'b1;
    @(negedge clock);
    meas_ready = 1'b0;
    check("pushpop_ovf", a_ovf, 1'b0);
    check_head("pushpop_head", 3, 1'b1);
    meas_ready = 1'b1;
    for (int w = 3; w <= 6; w++) begin
      check_head("order", w, 1'b1);
      @(negedge clock);
    end
    check("order_empty", a_valid, 1'b0);
    meas_ready = 1'b0;

    // Reset mid-pulse discards queued entries and the partial count.
    pulse(2);
    check("pre_rst_valid", a_valid, 1'b1);
    sig_in = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", a_valid, 1'b0);
    check("mid_rst_data",  a_data,  16'd0);
    sig_in = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("post_rst_valid", a_valid, 1'b0);
    end
    meas_ready = 1'b1;
    pulse(4);
    check_head("post_rst", 4, 1'b1);
    @(negedge clock);
    meas_ready = 1'b0;
`else
    // High 3 / low 7 / high 2, no consumer until the end.
    sig_in = 1'b1;
    repeat (3) @(negedge clock);
    sig_in = 1'b0;
    repeat (7) @(negedge clock);
    sig_in = 1'b1;
    repeat (2) @(negedge clock);
    sig_in = 1'b0;
    @(negedge clock);
    meas_ready = 1'b1;
    check_head("low_e0", 3, 1'b1);
    @(negedge clock);
    check_head("low_e1", 7, 1'b0);
    @(negedge clock);
    check_head("low_e2", 2, 1'b1);
    @(negedge clock);
    check("low_empty", a_valid, 1'b0);
    meas_ready = 1'b0;

    // Reset mid-pulse: FIFO empties and the partial pulse is never reported.
    sig_in = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", a_valid, 1'b0);
    sig_in = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("post_rst_valid", a_valid, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
